// File: rtl/atmega_eep_pkg.sv
// Shared types and constants for the ATmega-style EEPROM controller.
package atmega_eep_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    FETCH  = 3'd2,
    PROG   = 3'd3,
    COMMIT = 3'd4,
    EXT    = 3'd5
  } eep_state_e;

  localparam int unsigned EECR_EERE    = 0;
  localparam int unsigned EECR_EEPE    = 1;
  localparam int unsigned EECR_EEMPE   = 2;
  localparam int unsigned EECR_EERIE   = 3;
  localparam int unsigned EECR_EEPM_LO = 4;

  localparam logic [1:0] EEPM_ATOMIC = 2'b00;
  localparam logic [1:0] EEPM_ERASE  = 2'b01;
  localparam logic [1:0] EEPM_WRITE  = 2'b10;
  localparam logic [1:0] EEPM_RSVD   = 2'b11;

  localparam logic [7:0] ERASED_BYTE = 8'hFF;

  // Value stored at commit: programming can only clear bits, erase sets all.
  function automatic logic [7:0] commit_byte(input logic [1:0] mode,
                                             input logic [7:0] old_byte,
                                             input logic [7:0] new_byte);
    case (mode)
      EEPM_ERASE: commit_byte = ERASED_BYTE;
      EEPM_WRITE: commit_byte = old_byte & new_byte;
      default:    commit_byte = new_byte;
    endcase
  endfunction

endpackage

// File: rtl/atmega_eep_ram.sv
// Single-port synchronous byte array, erased (0xFF) at power-up, read-first.
module atmega_eep_ram
  import atmega_eep_pkg::*;
#(
  parameter int unsigned EEP_SIZE = 1024,
  parameter int unsigned ADDR_W   = $clog2(EEP_SIZE)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [7:0]        wdata_i,
  output logic [7:0]        rdata_o
);

  logic [7:0] mem [EEP_SIZE] = '{default: ERASED_BYTE};
  logic [7:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem[addr_i] <= wdata_i;
  end

  // Read data holds between read strobes so the controller can reuse it.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)    rdata_q <= '0;
    else if (re_i) rdata_q <= mem[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/atmega_eep_prog.sv
// ATmega-style EEPROM controller: I/O registers, EEMPE arming, timed
// erase/write programming, EE_RDY interrupt and an external direct-access port.
module atmega_eep_prog
  import atmega_eep_pkg::*;
#(
  parameter int unsigned BUS_ADDR_DATA_LEN = 8,
  parameter int unsigned EEARH_ADDR        = 'h20,
  parameter int unsigned EEARL_ADDR        = 'h21,
  parameter int unsigned EEDR_ADDR         = 'h22,
  parameter int unsigned EECR_ADDR         = 'h23,
  parameter int unsigned EEP_SIZE          = 1024,
  parameter int unsigned ADDR_W            = $clog2(EEP_SIZE),
  parameter int unsigned PROG_CYCLES       = 16,
  parameter int unsigned MPE_WINDOW        = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [BUS_ADDR_DATA_LEN-1:0] addr_i,
  input  logic                         wr_i,
  input  logic                         rd_i,
  input  logic [7:0]                   bus_i,
  output logic [7:0]                   bus_o,
  output logic                         int_o,
  input  logic                         ext_req_i,
  output logic                         ext_gnt_o,
  input  logic [ADDR_W-1:0]            ext_addr_i,
  input  logic                         ext_wr_i,
  input  logic [7:0]                   ext_data_i,
  input  logic                         ext_rd_i,
  output logic [7:0]                   ext_data_o,
  output logic                         ext_valid_o,
  output logic                         content_modified_o,
  output logic [4:0]                   debug_o
);

  localparam int unsigned MCNT_W    = $clog2(MPE_WINDOW + 1);
  localparam int unsigned PCNT_W    = $clog2(2 * PROG_CYCLES + 1);
  localparam logic [15:0] EEAR_MASK = 16'(EEP_SIZE - 1);

  eep_state_e          state_q, state_d;
  logic [15:0]         eear_q, eear_d;
  logic [7:0]          eedr_wr_q, eedr_wr_d, eedr_rd_q, eedr_rd_d;
  logic [1:0]          eepm_q, eepm_d;
  logic                eerie_q, eerie_d, busy_q, busy_d;
  logic [MCNT_W-1:0]   mcnt_q, mcnt_d;
  logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
  logic [ADDR_W-1:0]   prog_addr_q, prog_addr_d;
  logic [7:0]          prog_data_q, prog_data_d;
  logic [1:0]          prog_mode_q, prog_mode_d;
  logic                rd_pend_q, rd_pend_d, gnt_q, gnt_d;
  logic                ext_valid_q, ext_valid_d, mod_q, mod_d, int_q, int_d;

  logic [ADDR_W-1:0]   ram_addr;
  logic                ram_we, ram_re;
  logic [7:0]          ram_wdata, ram_rdata;

  logic sel_eearh, sel_eearl, sel_eedr, sel_eecr;
  logic wr_eecr, mpe_armed, start_prog, start_read;

  assign sel_eearh  = addr_i == BUS_ADDR_DATA_LEN'(EEARH_ADDR);
  assign sel_eearl  = addr_i == BUS_ADDR_DATA_LEN'(EEARL_ADDR);
  assign sel_eedr   = addr_i == BUS_ADDR_DATA_LEN'(EEDR_ADDR);
  assign sel_eecr   = addr_i == BUS_ADDR_DATA_LEN'(EECR_ADDR);
  assign wr_eecr    = wr_i & sel_eecr;
  assign mpe_armed  = mcnt_q != '0;
  assign start_prog = wr_eecr & bus_i[EECR_EEPE] & mpe_armed & (state_q == IDLE)
                    & ~gnt_q & (bus_i[EECR_EEPM_LO +: 2] != EEPM_RSVD);
  assign start_read = wr_eecr & bus_i[EECR_EERE] & (state_q == IDLE) & ~gnt_q & ~start_prog;

  always_comb begin
    state_d     = state_q;
    eear_d      = eear_q;
    eedr_wr_d   = eedr_wr_q;
    eedr_rd_d   = eedr_rd_q;
    eepm_d      = eepm_q;
    eerie_d     = eerie_q;
    busy_d      = busy_q;
    mcnt_d      = mpe_armed ? mcnt_q - MCNT_W'(1) : '0;
    pcnt_d      = pcnt_q;
    prog_addr_d = prog_addr_q;
    prog_data_d = prog_data_q;
    prog_mode_d = prog_mode_q;
    rd_pend_d   = 1'b0;
    gnt_d       = gnt_q;
    ext_valid_d = 1'b0;
    mod_d       = 1'b0;
    ram_addr    = eear_q[ADDR_W-1:0];
    ram_we      = 1'b0;
    ram_re      = 1'b0;
    ram_wdata   = prog_data_q;

    // Only EERIE stays writable while a programming operation is in flight.
    if (wr_eecr) eerie_d = bus_i[EECR_EERIE];
    if (!busy_q && wr_i) begin
      if (sel_eearh) eear_d = {bus_i, eear_q[7:0]} & EEAR_MASK;
      if (sel_eearl) eear_d = {eear_q[15:8], bus_i} & EEAR_MASK;
      if (sel_eedr)  eedr_wr_d = bus_i;
      if (sel_eecr) begin
        eepm_d = bus_i[EECR_EEPM_LO +: 2];
        if (bus_i[EECR_EEMPE] && !bus_i[EECR_EEPE]) mcnt_d = MCNT_W'(MPE_WINDOW);
      end
    end

    if (rd_pend_q) eedr_rd_d = ram_rdata;

    case (state_q)
      IDLE: begin
        if (start_prog) begin
          state_d     = FETCH;
          busy_d      = 1'b1;
          mcnt_d      = '0;
          prog_addr_d = eear_q[ADDR_W-1:0];
          prog_data_d = eedr_wr_q;
          prog_mode_d = bus_i[EECR_EEPM_LO +: 2];
        end else if (start_read) begin
          state_d = READ;
        end else if (ext_req_i) begin
          state_d = EXT;
          gnt_d   = 1'b1;
        end
      end
      READ: begin
        ram_re    = 1'b1;
        rd_pend_d = 1'b1;
        state_d   = IDLE;
      end
      FETCH: begin
        ram_re   = 1'b1;
        ram_addr = prog_addr_q;
        pcnt_d   = (prog_mode_q == EEPM_ATOMIC) ? PCNT_W'(2 * PROG_CYCLES) : PCNT_W'(PROG_CYCLES);
        state_d  = PROG;
      end
      PROG: begin
        if (pcnt_q == PCNT_W'(1)) state_d = COMMIT;
        else                      pcnt_d  = pcnt_q - PCNT_W'(1);
      end
      COMMIT: begin
        ram_we    = 1'b1;
        ram_addr  = prog_addr_q;
        ram_wdata = commit_byte(prog_mode_q, ram_rdata, prog_data_q);
        mod_d     = 1'b1;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
      EXT: begin
        if (!ext_req_i) begin
          gnt_d   = 1'b0;
          state_d = IDLE;
        end else begin
          ram_addr    = ext_addr_i;
          ram_we      = ext_wr_i;
          ram_wdata   = ext_data_i;
          ram_re      = ext_rd_i;
          mod_d       = ext_wr_i;
          ext_valid_d = ext_rd_i;
        end
      end
      default: state_d = IDLE;
    endcase

    int_d = eerie_d & ~busy_d;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      eear_q      <= '0;
      eedr_wr_q   <= '0;
      eedr_rd_q   <= '0;
      eepm_q      <= '0;
      eerie_q     <= 1'b0;
      busy_q      <= 1'b0;
      mcnt_q      <= '0;
      pcnt_q      <= '0;
      prog_addr_q <= '0;
      prog_data_q <= '0;
      prog_mode_q <= '0;
      rd_pend_q   <= 1'b0;
      gnt_q       <= 1'b0;
      ext_valid_q <= 1'b0;
      mod_q       <= 1'b0;
      int_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      eear_q      <= eear_d;
      eedr_wr_q   <= eedr_wr_d;
      eedr_rd_q   <= eedr_rd_d;
      eepm_q      <= eepm_d;
      eerie_q     <= eerie_d;
      busy_q      <= busy_d;
      mcnt_q      <= mcnt_d;
      pcnt_q      <= pcnt_d;
      prog_addr_q <= prog_addr_d;
      prog_data_q <= prog_data_d;
      prog_mode_q <= prog_mode_d;
      rd_pend_q   <= rd_pend_d;
      gnt_q       <= gnt_d;
      ext_valid_q <= ext_valid_d;
      mod_q       <= mod_d;
      int_q       <= int_d;
    end
  end

  atmega_eep_ram #(
    .EEP_SIZE (EEP_SIZE),
    .ADDR_W   (ADDR_W)
  ) u_ram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .addr_i  (ram_addr),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  // CPU read mux; EEDR returns the last array read, EERE reads set only during READ.
  always_comb begin
    bus_o = '0;
    if (rd_i) begin
      if (sel_eearh)      bus_o = eear_q[15:8];
      else if (sel_eearl) bus_o = eear_q[7:0];
      else if (sel_eedr)  bus_o = eedr_rd_q;
      else if (sel_eecr)  bus_o = {2'b00, eepm_q, eerie_q, mpe_armed, busy_q, state_q == READ};
    end
  end

  assign int_o              = int_q;
  assign ext_gnt_o          = gnt_q;
  assign ext_valid_o        = ext_valid_q;
  assign ext_data_o         = ext_valid_q ? ram_rdata : 8'h00;
  assign content_modified_o = mod_q;
  assign debug_o            = {busy_q, 3'(state_q), mpe_armed};

endmodule

// File: tb/tb_atmega_eep_prog.sv
// Directed bench for atmega_eep_prog: register access, programming modes,
// arming window, busy lockout, reset abort and the external port.
module tb_atmega_eep_prog;

  localparam logic [7:0] A_EEARH = 8'h20;
  localparam logic [7:0] A_EEARL = 8'h21;
  localparam logic [7:0] A_EEDR  = 8'h22;
  localparam logic [7:0] A_EECR  = 8'h23;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic [7:0] addr_i = '0;
  logic       wr_i = 1'b0, rd_i = 1'b0;
  logic [7:0] bus_i = '0;
  logic [7:0] bus_o;
  logic       int_o;
  logic       ext_req_i = 1'b0;
  logic       ext_gnt_o;
  logic [9:0] ext_addr_i = '0;
  logic       ext_wr_i = 1'b0, ext_rd_i = 1'b0;
  logic [7:0] ext_data_i = '0;
  logic [7:0] ext_data_o;
  logic       ext_valid_o;
  logic       content_modified_o;
  logic [4:0] debug_o;

  int n_vec = 0;
  int n_err = 0;

  atmega_eep_prog #(
    .BUS_ADDR_DATA_LEN (8),
    .EEARH_ADDR        ('h20),
    .EEARL_ADDR        ('h21),
    .EEDR_ADDR         ('h22),
    .EECR_ADDR         ('h23),
    .EEP_SIZE          (1024),
    .ADDR_W            (10),
    .PROG_CYCLES       (16),
    .MPE_WINDOW        (4)
  ) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .addr_i             (addr_i),
    .wr_i               (wr_i),
    .rd_i               (rd_i),
    .bus_i              (bus_i),
    .bus_o              (bus_o),
    .int_o              (int_o),
    .ext_req_i          (ext_req_i),
    .ext_gnt_o          (ext_gnt_o),
    .ext_addr_i         (ext_addr_i),
    .ext_wr_i           (ext_wr_i),
    .ext_data_i         (ext_data_i),
    .ext_rd_i           (ext_rd_i),
    .ext_data_o         (ext_data_o),
    .ext_valid_o        (ext_valid_o),
    .content_modified_o (content_modified_o),
    .debug_o            (debug_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic io_wr(input logic [7:0] a, input logic [7:0] d);
    addr_i = a; bus_i = d; wr_i = 1'b1;
    tick();
    wr_i = 1'b0;
  endtask

  task automatic io_rd(input logic [7:0] a, output logic [7:0] d);
    addr_i = a; rd_i = 1'b1;
    #1;
    d = bus_o;
    rd_i = 1'b0;
  endtask

  task automatic set_eear(input logic [15:0] a);
    io_wr(A_EEARH, a[15:8]);
    io_wr(A_EEARL, a[7:0]);
  endtask

  task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
    set_eear(a);
    io_wr(A_EECR, 8'h01);
    tick();
    tick();
    io_rd(A_EEDR, d);
  endtask

  task automatic start_prog(input logic [15:0] a, input logic [7:0] d, input logic [1:0] m);
    set_eear(a);
    io_wr(A_EEDR, d);
    io_wr(A_EECR, {2'b00, m, 4'b0100});
    io_wr(A_EECR, {2'b00, m, 4'b0010});
  endtask

  // Samples EEPE once per clock until it drops; the exit sample is included.
  task automatic wait_idle(output int busy_n, output int pulses, output bit timeout);
    logic [7:0] r;
    busy_n = 0; pulses = 0; timeout = 1'b1;
    for (int i = 0; i < 200; i++) begin
      io_rd(A_EECR, r);
      if (content_modified_o) pulses++;
      if (!r[1]) begin
        timeout = 1'b0;
        break;
      end
      busy_n++;
      tick();
    end
  endtask

  task automatic test_reset();
    logic [7:0] r;
    logic [23:0] outs;
    addr_i = A_EECR; rd_i = 1'b1;
    #2;
    outs = {bus_o, debug_o, int_o, ext_gnt_o, ext_valid_o, content_modified_o, ext_data_o[7:2]};
    rd_i = 1'b0;
    n_vec++;
    if (outs !== 24'h0 || ext_data_o !== 8'h00) begin
      n_err++; $display("FAIL reset_outputs got=%h exp=000000", outs);
    end
    #20 rst_i = 1'b1;
    tick();
    cpu_read(16'h0100, r);
    n_vec++;
    if (r !== 8'hFF) begin n_err++; $display("FAIL init_erased got=%h exp=ff", r); end
    io_rd(A_EECR, r);
    n_vec++;
    if (r !== 8'h00) begin n_err++; $display("FAIL eere_selfclear got=%h exp=00", r); end
    io_wr(A_EEARH, 8'hFF);
    io_rd(A_EEARH, r);
    n_vec++;
    if (r !== 8'h03) begin n_err++; $display("FAIL eearh_mask got=%h exp=03", r); end
  endtask

  task automatic test_atomic_write();
    logic [7:0] r;
    int n, p;
    bit to;
    start_prog(16'h0012, 8'hA5, 2'b00);
    io_rd(A_EEDR, r);
    n_vec++;
    if (r !== 8'hFF) begin n_err++; $display("FAIL eedr_last_read got=%h exp=ff", r); end
    wait_idle(n, p, to);
    n_vec++;
    if (to || n != 34 || p != 1) begin
      n_err++; $display("FAIL atomic_busy got=%0d/%0d/%0d exp=34/1/0", n, p, to);
    end
    tick();
    n_vec++;
    if (content_modified_o !== 1'b0) begin n_err++; $display("FAIL atomic_pulse_width got=1 exp=0"); end
    set_eear(16'h0012);
    io_wr(A_EECR, 8'h01);
    tick();
    io_rd(A_EEDR, r);
    n_vec++;
    if (r !== 8'hFF) begin n_err++; $display("FAIL eedr_early got=%h exp=ff", r); end
    tick();
    io_rd(A_EEDR, r);
    n_vec++;
    if (r !== 8'hA5) begin n_err++; $display("FAIL eedr_after_read got=%h exp=a5", r); end
  endtask

  task automatic test_write_and_erase();
    logic [7:0] r;
    int n, p;
    bit to;
    start_prog(16'h0020, 8'hF0, 2'b00);
    wait_idle(n, p, to);
    start_prog(16'h0020, 8'h3C, 2'b10);
    wait_idle(n, p, to);
    n_vec++;
    if (to || n != 18 || p != 1) begin
      n_err++; $display("FAIL write_only_busy got=%0d/%0d/%0d exp=18/1/0", n, p, to);
    end
    cpu_read(16'h0020, r);
    n_vec++;
    if (r !== 8'h30) begin n_err++; $display("FAIL write_only_and got=%h exp=30", r); end
    start_prog(16'h0020, 8'h12, 2'b01);
    wait_idle(n, p, to);
    n_vec++;
    if (to || n != 18) begin n_err++; $display("FAIL erase_busy got=%0d exp=18", n); end
    cpu_read(16'h0020, r);
    n_vec++;
    if (r !== 8'hFF) begin n_err++; $display("FAIL erase_value got=%h exp=ff", r); end
  endtask

  task automatic test_window();
    logic [7:0] r;
    int n, p, pulses;
    bit to;
    set_eear(16'h0012);
    io_wr(A_EEDR, 8'h00);
    io_wr(A_EECR, 8'h14);
    io_rd(A_EECR, r);
    n_vec++;
    if (r !== 8'h14) begin n_err++; $display("FAIL mpe_armed got=%h exp=14", r); end
    for (int i = 0; i < 4; i++) tick();
    io_rd(A_EECR, r);
    n_vec++;
    if (r !== 8'h10) begin n_err++; $display("FAIL mpe_expired got=%h exp=10", r); end
    io_wr(A_EECR, 8'h12);
    io_rd(A_EECR, r);
    n_vec++;
    if (r !== 8'h10) begin n_err++; $display("FAIL late_eepe_ignored got=%h exp=10", r); end
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (content_modified_o) pulses++;
      tick();
    end
    cpu_read(16'h0012, r);
    n_vec++;
    if (r !== 8'hA5 || pulses != 0) begin
      n_err++; $display("FAIL late_array got=%h/%0d exp=a5/0", r, pulses);
    end
    io_wr(A_EECR, 8'h14);
    for (int i = 0; i < 3; i++) tick();
    io_wr(A_EECR, 8'h12);
    io_rd(A_EECR, r);
    n_vec++;
    if (r !== 8'h12) begin n_err++; $display("FAIL last_window_clk got=%h exp=12", r); end
    wait_idle(n, p, to);
    n_vec++;
    if (to || n != 18 || p != 1) begin
      n_err++; $display("FAIL last_window_busy got=%0d/%0d/%0d exp=18/1/0", n, p, to);
    end
    cpu_read(16'h0012, r);
    n_vec++;
    if (r !== 8'hFF) begin n_err++; $display("FAIL last_window_erase got=%h exp=ff", r); end
    io_wr(A_EECR, 8'h34);
    io_wr(A_EECR, 8'h32);
    io_rd(A_EECR, r);
    n_vec++;
    if (r !== 8'h34 || debug_o[3:1] !== 3'd0) begin
      n_err++; $display("FAIL rsvd_no_start got=%h/%h exp=34/0", r, debug_o[3:1]);
    end
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (content_modified_o) pulses++;
      tick();
    end
    n_vec++;
    if (pulses != 0) begin n_err++; $display("FAIL rsvd_no_pulse got=%0d exp=0", pulses); end
  endtask

  task automatic test_busy_lockout();
    logic [7:0] r;
    int n, p;
    bit to;
    start_prog(16'h0030, 8'h5A, 2'b00);
    for (int i = 0; i < 3; i++) tick();
    io_wr(A_EECR, 8'h08);
    io_wr(A_EEARL, 8'h55);
    io_wr(A_EEDR, 8'h00);
    io_rd(A_EEARL, r);
    n_vec++;
    if (r !== 8'h30) begin n_err++; $display("FAIL eear_locked got=%h exp=30", r); end
    io_rd(A_EECR, r);
    n_vec++;
    if (r !== 8'h0A || int_o !== 1'b0) begin
      n_err++; $display("FAIL eerie_while_busy got=%h/%b exp=0a/0", r, int_o);
    end
    wait_idle(n, p, to);
    n_vec++;
    if (to || int_o !== 1'b1) begin n_err++; $display("FAIL int_on_done got=%b exp=1", int_o); end
    io_wr(A_EECR, 8'h00);
    n_vec++;
    if (int_o !== 1'b0) begin n_err++; $display("FAIL int_cleared got=%b exp=0", int_o); end
    cpu_read(16'h0030, r);
    n_vec++;
    if (r !== 8'h5A) begin n_err++; $display("FAIL locked_data got=%h exp=5a", r); end
  endtask

  task automatic test_reset_mid_prog();
    logic [7:0] r;
    logic [23:0] outs;
    int n, p;
    bit to;
    start_prog(16'h0040, 8'h11, 2'b00);
    wait_idle(n, p, to);
    start_prog(16'h0040, 8'h99, 2'b00);
    for (int i = 0; i < 9; i++) tick();
    n_vec++;
    if (debug_o !== 5'h16) begin n_err++; $display("FAIL debug_in_prog got=%h exp=16", debug_o); end
    rst_i = 1'b0;
    #1;
    addr_i = A_EEARL; rd_i = 1'b1;
    #1;
    outs = {bus_o, debug_o, int_o, ext_gnt_o, ext_valid_o, content_modified_o, ext_data_o[7:2]};
    rd_i = 1'b0;
    n_vec++;
    if (outs !== 24'h0 || ext_data_o !== 8'h00) begin
      n_err++; $display("FAIL reset_mid_outputs got=%h exp=000000", outs);
    end
    #2 rst_i = 1'b1;
    tick();
    cpu_read(16'h0040, r);
    n_vec++;
    if (r !== 8'h11) begin n_err++; $display("FAIL reset_abort_array got=%h exp=11", r); end
  endtask

  task automatic test_ext_port();
    logic [7:0] r;
    bit gnt_seen, to;
    ext_addr_i = 10'h3FF; ext_data_i = 8'h00; ext_wr_i = 1'b1;
    tick();
    ext_wr_i = 1'b0;
    n_vec++;
    if (content_modified_o !== 1'b0) begin n_err++; $display("FAIL ext_wr_no_gnt got=1 exp=0"); end
    ext_rd_i = 1'b1;
    tick();
    ext_rd_i = 1'b0;
    n_vec++;
    if (ext_valid_o !== 1'b0) begin n_err++; $display("FAIL ext_rd_no_gnt got=1 exp=0"); end
    start_prog(16'h0050, 8'h66, 2'b00);
    ext_req_i = 1'b1;
    gnt_seen = 1'b0; to = 1'b1;
    for (int i = 0; i < 200; i++) begin
      io_rd(A_EECR, r);
      if (ext_gnt_o) gnt_seen = 1'b1;
      if (!r[1]) begin
        to = 1'b0;
        break;
      end
      tick();
    end
    n_vec++;
    if (to || gnt_seen) begin n_err++; $display("FAIL gnt_blocked_busy got=%b/%b exp=0/0", gnt_seen, to); end
    tick();
    n_vec++;
    if (ext_gnt_o !== 1'b1) begin n_err++; $display("FAIL gnt_after_commit got=0 exp=1"); end
    ext_addr_i = 10'h3FF; ext_data_i = 8'h7F; ext_wr_i = 1'b1;
    tick();
    ext_wr_i = 1'b0;
    n_vec++;
    if (content_modified_o !== 1'b1) begin n_err++; $display("FAIL ext_wr_pulse got=0 exp=1"); end
    ext_rd_i = 1'b1;
    tick();
    ext_rd_i = 1'b0;
    n_vec++;
    if ({ext_valid_o, ext_data_o} !== 9'h17F) begin
      n_err++; $display("FAIL ext_rd_data got=%b/%h exp=1/7f", ext_valid_o, ext_data_o);
    end
    tick();
    n_vec++;
    if ({ext_valid_o, ext_data_o} !== 9'h000) begin
      n_err++; $display("FAIL ext_rd_idle got=%b/%h exp=0/00", ext_valid_o, ext_data_o);
    end
    io_wr(A_EECR, 8'h04);
    io_wr(A_EECR, 8'h02);
    io_rd(A_EECR, r);
    n_vec++;
    if (r !== 8'h04 || debug_o !== 5'h0B) begin
      n_err++; $display("FAIL cpu_eepe_granted got=%h/%h exp=04/0b", r, debug_o);
    end
    ext_req_i = 1'b0;
    tick();
    n_vec++;
    if (ext_gnt_o !== 1'b0) begin n_err++; $display("FAIL gnt_release got=1 exp=0"); end
    for (int i = 0; i < 4; i++) tick();
    cpu_read(16'h03FF, r);
    n_vec++;
    if (r !== 8'h7F) begin n_err++; $display("FAIL ext_written got=%h exp=7f", r); end
    cpu_read(16'h0050, r);
    n_vec++;
    if (r !== 8'h66) begin n_err++; $display("FAIL prog_before_gnt got=%h exp=66", r); end
  endtask

  initial begin
    test_reset();
    test_atomic_write();
    test_write_and_erase();
    test_window();
    test_busy_lockout();
    test_reset_mid_prog();
    test_ext_port();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
